// File: rtl/c432_key_loader_if.sv
// c432_key_loader_if: key-load bus between the key source and c432_key_loader.
//
// Protocol: there is no valid/ready pair. KEY_SE and KEY_LD are requests that the
// loader honours only while KEY_BUSY is low. Requests made while KEY_BUSY is high
// are dropped, never queued. KEY_LD is a one-cycle pulse, and a KEY_SE in the same
// cycle as KEY_LD is ignored. The key source watches KEY_BUSY, KEY_OK and KEY_ERR
// to learn the outcome of a commit. state_dbg exposes the loader FSM state.
interface c432_key_loader_if #(
   parameter int KEY_W = 20
);
   logic             KEY_SI;
   logic             KEY_SE;
   logic             KEY_LD;
   logic [KEY_W-1:0] D;
   logic             KEY_BUSY;
   logic             KEY_OK;
   logic             KEY_ERR;
   logic [1:0]       state_dbg;

   // Key source side
   modport master (
      output KEY_SI, KEY_SE, KEY_LD,
      input  D, KEY_BUSY, KEY_OK, KEY_ERR, state_dbg
   );

   // Loader side
   modport slave (
      input  KEY_SI, KEY_SE, KEY_LD,
      output D, KEY_BUSY, KEY_OK, KEY_ERR, state_dbg
   );
endinterface

// File: rtl/c432_key_loader.sv
// c432_key_loader: serial unlock-key loader for the key-locked c432 netlist.
//
// The key arrives MSB-first, one bit per shift, into a shadow register. A commit
// pulse checks the shift count and, optionally, an even-parity bit. An accepted
// commit copies the key into the held register D that drives the D_0..D_19 mux
// selects. D never shows a partially shifted key.
//
// Optional feature macro: KEY_PARITY_EN. When it is defined, the loader expects
// one trailing even-parity bit after the key bits, so 21 bits are shifted in.
//
// Every output comes straight from a flop.
module c432_key_loader #(
   parameter int KEY_W = 20
) (
   input  logic              CK,
   input  logic              RST,
   c432_key_loader_if.slave  bus
);

`ifdef KEY_PARITY_EN
   localparam int N = KEY_W + 1;
`else
   localparam int N = KEY_W;
`endif
   localparam logic [4:0] CNT_FULL = 5'(N);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     shadow_q, shadow_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             parity_ok;
   logic             accept;

   // The candidate key is always the oldest KEY_W bits of the shadow register.
   // With parity, shadow[0] holds the trailing parity bit.
`ifdef KEY_PARITY_EN
   assign parity_ok = ((^shadow_q[N-1 -: KEY_W]) == shadow_q[0]);
`else
   assign parity_ok = 1'b1;
`endif

   // A commit succeeds only after a full N-bit load since the last commit or reset.
   assign accept = (cnt_q == CNT_FULL) && parity_ok;

   // FSM state register
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a commit pulse in IDLE starts CHECK; CHECK either applies or rejects
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.KEY_LD) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = accept ? ST_APPLY : ST_IDLE;
         end
         ST_APPLY: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs and datapath next values; CHECK and APPLY ignore KEY_SE/KEY_LD
   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      key_d    = key_q;
      ok_d     = ok_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            // A commit takes priority, so a shift requested in the commit cycle is
            // dropped and the check sees the count and shadow as they were.
            if (!bus.KEY_LD && bus.KEY_SE) begin
               shadow_d = {shadow_q[N-2:0], bus.KEY_SI};
               if (cnt_q != CNT_FULL) begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         ST_CHECK: begin
            // A rejected commit leaves D and KEY_OK alone. A fresh full load is
            // needed before the next attempt.
            if (!accept) begin
               err_d = 1'b1;
               cnt_d = '0;
            end
         end
         ST_APPLY: begin
            // The shadow register keeps its contents. Clearing the count alone
            // forces a full reload before the next accepted commit.
            key_d = shadow_q[N-1 -: KEY_W];
            ok_d  = 1'b1;
            err_d = 1'b0;
            cnt_d = '0;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // BUSY is registered from the next state, so it is high exactly while in CHECK/APPLY.
   assign busy_d = (state_d != ST_IDLE);

   // Datapath and status registers; reset discards any partial key
   always_ff @(posedge CK) begin
      if (RST) begin
         shadow_q <= '0;
         cnt_q    <= '0;
         key_q    <= '0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.D         = key_q;
   assign bus.KEY_BUSY  = busy_q;
   assign bus.KEY_OK    = ok_q;
   assign bus.KEY_ERR   = err_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// tb_c432_key_loader: checks c432_key_loader against a bit-history reference model.
// The bench also honours KEY_PARITY_EN when that macro is defined.
module tb_c432_key_loader;
   localparam int KEY_W = 20;
`ifdef KEY_PARITY_EN
   localparam int N = KEY_W + 1;
`else
   localparam int N = KEY_W;
`endif

   // ---------------- clock / reset ----------------
   logic ck = 1'b0;
   logic rst;
   always #5 ck = ~ck;

   c432_key_loader_if #(.KEY_W(KEY_W)) kif ();

   c432_key_loader #(.KEY_W(KEY_W)) dut (
      .CK  (ck),
      .RST (rst),
      .bus (kif)
   );

   // ---------------- scoreboard / reference model ----------------
   int total = 0;
   int bad   = 0;
   logic [KEY_W-1:0] exp_q[$];   // keys accepted and waiting to reach D
   bit               hist[$];    // last N bits shifted, oldest first
   int               since;      // bits shifted since the last commit or reset, capped at N
   int               busy_left;  // remaining busy cycles of the current commit
   bit               pend_acc;
   logic [KEY_W-1:0] m_d;
   bit               m_ok;
   bit               m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(1'b0);
      exp_q.delete();
      since     = 0;
      busy_left = 0;
      pend_acc  = 1'b0;
      m_d       = '0;
      m_ok      = 1'b0;
      m_err     = 1'b0;
   endfunction

   function automatic logic [KEY_W-1:0] hist_key();
      logic [KEY_W-1:0] k = '0;
      for (int i = 0; i < KEY_W; i++) k = {k[KEY_W-2:0], hist[i]};
      return k;
   endfunction

   function automatic bit hist_par_ok();
`ifdef KEY_PARITY_EN
      logic [KEY_W-1:0] k = hist_key();
      return ((^k) == hist[N-1]);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_edge(input bit se, input bit si, input bit ld, input bit r);
      if (r) begin
         model_reset();
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            if (pend_acc) begin
               m_d   = exp_q.pop_front();
               m_ok  = 1'b1;
               m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
            since = 0;
         end
      end else if (ld) begin
         pend_acc = (since == N) && hist_par_ok();
         if (pend_acc) exp_q.push_back(hist_key());
         busy_left = pend_acc ? 2 : 1;
      end else if (se) begin
         hist.push_back(si);
         void'(hist.pop_front());
         if (since < N) since++;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit se, input bit si, input bit ld, input bit r);
      kif.KEY_SE = se;
      kif.KEY_SI = si;
      kif.KEY_LD = ld;
      rst        = r;
      @(posedge ck);
      model_edge(se, si, ld, r);
      #1;
      check("D", 32'(kif.D), 32'(m_d));
      check("BUSY", 32'(kif.KEY_BUSY), 32'(busy_left > 0));
      check("OK", 32'(kif.KEY_OK), 32'(m_ok));
      check("ERR", 32'(kif.KEY_ERR), 32'(m_err));
   endtask

   function automatic logic [N-1:0] make_frame(input logic [KEY_W-1:0] key, input bit bad_par);
`ifdef KEY_PARITY_EN
      return {key, (^key) ^ bad_par};
`else
      return (bad_par == 1'b1) ? key : key;
`endif
   endfunction

   // Shift nshift bits. Over-long loads prepend random bits so that the frame ends up last.
   task automatic shift_frame(input logic [N-1:0] fr, input int nshift);
      if (nshift > N) begin
         for (int i = 0; i < nshift - N; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         for (int j = 0; j < N; j++) cycle(1'b1, fr[N-1-j], 1'b0, 1'b0);
      end else begin
         for (int j = 0; j < nshift; j++) cycle(1'b1, fr[N-1-j], 1'b0, 1'b0);
      end
   endtask

   // Pulse LD, then idle three cycles, counting cycles with BUSY seen high.
   task automatic commit(output int busy_n);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      busy_n = int'(kif.KEY_BUSY);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         busy_n += int'(kif.KEY_BUSY);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [KEY_W-1:0] key;
      int               nshift;
      bit               bad_par;
      logic [KEY_W-1:0] exp_d;
      bit               exp_ok;
      bit               exp_err;
      int               exp_busy;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int busy_n;
      logic [N-1:0] fr;
      vec_t v;

      vecs.push_back('{20'hA5C3F, N,  1'b0, 20'hA5C3F, 1'b1, 1'b0, 2});
      vecs.push_back('{20'h3FFFF, 19, 1'b0, 20'hA5C3F, 1'b1, 1'b1, 1});
      vecs.push_back('{20'h00001, N,  1'b0, 20'h00001, 1'b1, 1'b0, 2});
      vecs.push_back('{20'h12345, 25, 1'b0, 20'h12345, 1'b1, 1'b0, 2});
      vecs.push_back('{20'h0F0F0, 0,  1'b0, 20'h12345, 1'b1, 1'b1, 1});
`ifdef KEY_PARITY_EN
      vecs.push_back('{20'hA5C3F, N,  1'b1, 20'h12345, 1'b1, 1'b1, 1});
`endif
      vecs.push_back('{20'hFFFFF, N,  1'b0, 20'hFFFFF, 1'b1, 1'b0, 2});

      kif.KEY_SE = 1'b0;
      kif.KEY_SI = 1'b0;
      kif.KEY_LD = 1'b0;
      rst        = 1'b1;
      model_reset();

      // Power-on reset
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("por_D", 32'(kif.D), 32'h0);

      // Reset mid-shift, then a commit with no shifts must be rejected at t+1
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      check("rst_D", 32'(kif.D), 32'h0);
      check("rst_OK", 32'(kif.KEY_OK), 32'h0);
      check("rst_ERR", 32'(kif.KEY_ERR), 32'h0);
      check("rst_BUSY", 32'(kif.KEY_BUSY), 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check("rst_ld_busy_t", 32'(kif.KEY_BUSY), 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_ld_err_t1", 32'(kif.KEY_ERR), 32'h1);
      check("rst_ld_busy_t1", 32'(kif.KEY_BUSY), 32'h0);

      // Table-driven loads
      for (int i = 0; i < vecs.size(); i++) begin
         v  = vecs[i];
         fr = make_frame(v.key, v.bad_par);
         shift_frame(fr, v.nshift);
         commit(busy_n);
         check($sformatf("vec%0d_D", i), 32'(kif.D), 32'(v.exp_d));
         check($sformatf("vec%0d_OK", i), 32'(kif.KEY_OK), 32'(v.exp_ok));
         check($sformatf("vec%0d_ERR", i), 32'(kif.KEY_ERR), 32'(v.exp_err));
         check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(v.exp_busy));
      end

      // SE together with LD: the bit is not shifted, so N-1 bits give a reject
      fr = make_frame(20'h5A5A5, 1'b0);
      shift_frame(fr, N - 1);
      cycle(1'b1, fr[0], 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("se_ld_ERR", 32'(kif.KEY_ERR), 32'h1);
      check("se_ld_D", 32'(kif.D), 32'hFFFFF);

      // SE/LD during BUSY are ignored: D gets the loaded key and count stays cleared
      fr = make_frame(20'h0C3A5, 1'b0);
      shift_frame(fr, N);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check("busy_col_D", 32'(kif.D), 32'h0C3A5);
      check("busy_col_ERR", 32'(kif.KEY_ERR), 32'h0);
      check("busy_col_BUSY", 32'(kif.KEY_BUSY), 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("busy_col_recheck_ERR", 32'(kif.KEY_ERR), 32'h1);
      check("busy_col_recheck_D", 32'(kif.D), 32'h0C3A5);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         cycle($urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)),
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 499) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
